// File: rtl/ldtu_bs_multi_auto_if.sv
// Sample, baseline-configuration and calibration-status bundle
// for the LiTe-DTU baseline-subtraction stage.
interface ldtu_bs_multi_auto_if #(
    parameter int NCH     = 2,
    parameter int NB_DATA = 12,
    parameter int NB_BSL  = 8
);
    logic [NCH*NB_DATA-1:0] data_in;
    logic [NCH*NB_BSL-1:0]  bsl_manual;
    logic                   mode_auto;
    logic                   calib_start;
    logic [NCH*NB_DATA-1:0] data_out;
    logic [NCH-1:0]         sat_flag;
    logic [NCH*NB_BSL-1:0]  bsl_active;
    logic                   calib_busy;
    logic                   calib_done;

    modport master (
        output data_in, bsl_manual, mode_auto, calib_start,
        input  data_out, sat_flag, bsl_active, calib_busy, calib_done
    );

    modport slave (
        input  data_in, bsl_manual, mode_auto, calib_start,
        output data_out, sat_flag, bsl_active, calib_busy, calib_done
    );
endinterface

// File: rtl/ldtu_bs_multi_auto.sv
// Multi-channel baseline subtraction with zero-saturation and an
// averaging calibration engine that can supply the baseline.
module ldtu_bs_multi_auto #(
    parameter int NCH        = 2,
    parameter int NB_DATA    = 12,
    parameter int NB_BSL     = 8,
    parameter int LOG2_NSAMP = 4
) (
    input  logic                 DCLK,
    input  logic                 reset,
    ldtu_bs_multi_auto_if.slave  bus
);
    localparam int NB_ACC = NB_DATA + LOG2_NSAMP + 1;
    localparam int NB_AVG = NB_ACC - LOG2_NSAMP;
    localparam logic [LOG2_NSAMP-1:0] CNT_LAST = '1;
    localparam logic [NB_ACC-1:0] HALF = NB_ACC'(2 ** (LOG2_NSAMP - 1));
    localparam logic [NB_AVG-1:0] BSL_MAX = NB_AVG'(2 ** NB_BSL - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t                state;
    state_t                state_nx;
    logic                  acc_clr;
    logic                  acc_en;
    logic                  bsl_upd;
    logic [LOG2_NSAMP-1:0] cnt;
    logic                  done;

    always_comb begin
        state_nx = state;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        bsl_upd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.calib_start) begin
                    acc_clr  = 1'b1;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (cnt == CNT_LAST) state_nx = UPDATE;
            end
            UPDATE: begin
                bsl_upd  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge DCLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge DCLK or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (acc_clr)     cnt <= '0;
            else if (acc_en) cnt <= cnt + 1'b1;
            if (acc_clr)      done <= 1'b0;
            else if (bsl_upd) done <= 1'b1;
        end
    end

    assign bus.calib_busy = (state != IDLE);
    assign bus.calib_done = done;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [NB_DATA-1:0] d_r;
        logic [NB_DATA-1:0] dout;
        logic               sat;
        logic [NB_BSL-1:0]  bsl_auto;
        logic [NB_BSL-1:0]  bsl_act;
        logic [NB_DATA-1:0] bsl_ext;
        logic [NB_ACC-1:0]  acc;
        logic [NB_AVG-1:0]  avg;

        assign bsl_act = bus.mode_auto ? bsl_auto
                                       : bus.bsl_manual[c*NB_BSL +: NB_BSL];
        assign bsl_ext = NB_DATA'(bsl_act);
        assign avg     = NB_AVG'((acc + HALF) >> LOG2_NSAMP);

        always_ff @(posedge DCLK or posedge reset) begin
            if (reset) begin
                d_r  <= '0;
                dout <= '0;
                sat  <= 1'b0;
            end else begin
                d_r <= bus.data_in[c*NB_DATA +: NB_DATA];
                if (d_r < bsl_ext) begin
                    dout <= '0;
                    sat  <= 1'b1;
                end else begin
                    dout <= d_r - bsl_ext;
                    sat  <= 1'b0;
                end
            end
        end

        always_ff @(posedge DCLK or posedge reset) begin
            if (reset)        acc <= '0;
            else if (acc_clr) acc <= '0;
            else if (acc_en)  acc <= acc + NB_ACC'(d_r);
        end

        // Rounded mean clamps to the widest representable baseline
        always_ff @(posedge DCLK or posedge reset) begin
            if (reset) begin
                bsl_auto <= '0;
            end else if (bsl_upd) begin
                bsl_auto <= (avg > BSL_MAX) ? '1 : avg[NB_BSL-1:0];
            end
        end

        assign bus.data_out[c*NB_DATA +: NB_DATA] = dout;
        assign bus.sat_flag[c]                    = sat;
        assign bus.bsl_active[c*NB_BSL +: NB_BSL] = bsl_act;
    end
endmodule

// File: tb/tb_ldtu_bs_multi_auto.sv
// Bench for ldtu_bs_multi_auto: vector table, calibration corner
// sequences and randomized traffic against a behavioural model.
module tb_ldtu_bs_multi_auto;
    localparam int NCH = 2;
    localparam int NB_DATA = 12;
    localparam int NB_BSL = 8;
    localparam int LOG2_NSAMP = 4;
    localparam int NS = 1 << LOG2_NSAMP;
    localparam int DMASK = (1 << NB_DATA) - 1;
    localparam int BMASK = (1 << NB_BSL) - 1;

    logic DCLK = 1'b0;
    logic reset;

    ldtu_bs_multi_auto_if #(
        .NCH(NCH), .NB_DATA(NB_DATA), .NB_BSL(NB_BSL)
    ) bus ();

    ldtu_bs_multi_auto #(
        .NCH(NCH), .NB_DATA(NB_DATA), .NB_BSL(NB_BSL),
        .LOG2_NSAMP(LOG2_NSAMP)
    ) dut (
        .DCLK(DCLK),
        .reset(reset),
        .bus(bus)
    );

    always #5 DCLK = ~DCLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge DCLK);
        #2;
    endtask

    // Behavioural model: sample history, running sums and a sample count
    int m_dr[NCH];
    int m_out[NCH];
    int m_sat[NCH];
    int m_bsl[NCH];
    int m_sum[NCH];
    bit m_busy;
    bit m_done;
    int m_n;

    function automatic int chan_d(input logic [NCH*NB_DATA-1:0] v, int c);
        return int'(v >> (c * NB_DATA)) & DMASK;
    endfunction

    function automatic int chan_b(input logic [NCH*NB_BSL-1:0] v, int c);
        return int'(v >> (c * NB_BSL)) & BMASK;
    endfunction

    always @(posedge DCLK or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_dr[c] = 0; m_out[c] = 0; m_sat[c] = 0;
                m_bsl[c] = 0; m_sum[c] = 0;
            end
            m_busy = 0; m_done = 0; m_n = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int b;
                b = bus.mode_auto ? m_bsl[c] : chan_b(bus.bsl_manual, c);
                if (m_dr[c] < b) begin
                    m_out[c] = 0; m_sat[c] = 1;
                end else begin
                    m_out[c] = m_dr[c] - b; m_sat[c] = 0;
                end
            end
            if (!m_busy) begin
                if (bus.calib_start) begin
                    m_busy = 1; m_n = 0; m_done = 0;
                    for (int c = 0; c < NCH; c++) m_sum[c] = 0;
                end
            end else if (m_n < NS) begin
                for (int c = 0; c < NCH; c++) m_sum[c] += m_dr[c];
                m_n++;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    int a;
                    a = (m_sum[c] + NS / 2) / NS;
                    m_bsl[c] = (a > BMASK) ? BMASK : a;
                end
                m_done = 1; m_busy = 0;
            end
            for (int c = 0; c < NCH; c++) m_dr[c] = chan_d(bus.data_in, c);
        end
    end

    always @(negedge DCLK) begin
        if (chk_en) begin
            logic [31:0] eo, es, eb;
            eo = '0; es = '0; eb = '0;
            for (int c = 0; c < NCH; c++) begin
                eo |= 32'(m_out[c]) << (c * NB_DATA);
                es |= 32'(m_sat[c]) << c;
                eb |= 32'(bus.mode_auto ? m_bsl[c]
                          : chan_b(bus.bsl_manual, c)) << (c * NB_BSL);
            end
            chk("model data_out", 32'(bus.data_out), eo);
            chk("model sat_flag", 32'(bus.sat_flag), es);
            chk("model bsl_active", 32'(bus.bsl_active), eb);
            chk("model calib_busy", 32'(bus.calib_busy), 32'(m_busy));
            chk("model calib_done", 32'(bus.calib_done), 32'(m_done));
        end
    end

    typedef struct {
        logic [11:0] d0, d1;
        logic [7:0]  b0, b1;
        logic [11:0] e0, e1;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl[6];

    task automatic calib(input logic [11:0] c0, input logic [11:0] c1a,
                         input logic [11:0] c1b, input int restart_at);
        bit seen_done;
        int n;
        int k;
        seen_done = 0;
        bus.data_in = {c1a, c0};
        bus.calib_start = 1'b1;
        step();
        bus.calib_start = 1'b0;
        n = 0;
        k = 1;
        while (bus.calib_busy && n < 40) begin
            n++;
            if (bus.calib_done) seen_done = 1;
            bus.data_in = {(k % 2 == 1) ? c1b : c1a, c0};
            bus.calib_start = (k == restart_at);
            k++;
            step();
        end
        bus.calib_start = 1'b0;
        chk("calib busy cycles", 32'(n), 32'd17);
        chk("calib_done low while busy", 32'(seen_done), 32'd0);
        chk("calib_done after update", 32'(bus.calib_done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.data_in = '0;
        bus.bsl_manual = '0;
        bus.mode_auto = 1'b0;
        bus.calib_start = 1'b0;
        step();
        chk("reset data_out", 32'(bus.data_out), 32'd0);
        chk("reset sat_flag", 32'(bus.sat_flag), 32'd0);
        chk("reset calib_busy", 32'(bus.calib_busy), 32'd0);
        chk("reset calib_done", 32'(bus.calib_done), 32'd0);
        chk_en = 1;
        reset = 1'b0;
        step();

        tbl[0] = '{12'h100, 12'hFFF, 8'h20, 8'h05, 12'h0E0, 12'hFFA, 2'b00};
        tbl[1] = '{12'h010, 12'h000, 8'h20, 8'h05, 12'h000, 12'h000, 2'b11};
        tbl[2] = '{12'h020, 12'h005, 8'h20, 8'h05, 12'h000, 12'h000, 2'b00};
        tbl[3] = '{12'hFFF, 12'h0FF, 8'hFF, 8'hFF, 12'hF00, 12'h000, 2'b00};
        tbl[4] = '{12'h0FE, 12'h100, 8'hFF, 8'hFF, 12'h000, 12'h001, 2'b01};
        tbl[5] = '{12'h000, 12'h7FF, 8'h00, 8'h80, 12'h000, 12'h77F, 2'b00};
        for (int i = 0; i < 6; i++) begin
            bus.mode_auto = 1'b0;
            bus.data_in = {tbl[i].d1, tbl[i].d0};
            bus.bsl_manual = {tbl[i].b1, tbl[i].b0};
            step();
            step();
            chk("vec data_out", 32'(bus.data_out), 32'({tbl[i].e1, tbl[i].e0}));
            chk("vec sat_flag", 32'(bus.sat_flag), 32'(tbl[i].es));
        end

        // Back-to-back underflow then exact match
        bus.bsl_manual = {8'h05, 8'h20};
        bus.data_in = {12'h100, 12'h010};
        step();
        bus.data_in = {12'h100, 12'h020};
        step();
        chk("underflow out", 32'(bus.data_out[11:0]), 32'h000);
        chk("underflow sat", 32'(bus.sat_flag[0]), 32'd1);
        step();
        chk("equal out", 32'(bus.data_out[11:0]), 32'h000);
        chk("equal sat", 32'(bus.sat_flag[0]), 32'd0);

        // Auto mode before any calibration applies zero
        bus.mode_auto = 1'b1;
        step();
        chk("auto precal bsl", 32'(bus.bsl_active), 32'h0);
        bus.mode_auto = 1'b0;

        calib(12'h050, 12'h030, 12'h031, -1);
        bus.mode_auto = 1'b1;
        step();
        chk("calib round bsl", 32'(bus.bsl_active), 32'h3150);
        bus.data_in = {12'h060, 12'h060};
        step();
        step();
        chk("auto subtract", 32'(bus.data_out), 32'({12'h02F, 12'h010}));

        calib(12'h300, 12'h040, 12'h040, -1);
        chk("clamp bsl", 32'(bus.bsl_active), 32'h40FF);
        bus.data_in = {12'h040, 12'h0FE};
        step();
        step();
        chk("clamp out", 32'(bus.data_out), 32'h0);
        chk("clamp sat", 32'(bus.sat_flag), 32'b01);

        calib(12'h050, 12'h030, 12'h031, 5);
        chk("restart bsl", 32'(bus.bsl_active), 32'h3150);

        // Abort during accumulation by reset
        bus.data_in = {12'h123, 12'h050};
        bus.calib_start = 1'b1;
        step();
        bus.calib_start = 1'b0;
        repeat (7) step();
        chk("abort busy before", 32'(bus.calib_busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("abort busy", 32'(bus.calib_busy), 32'd0);
        chk("abort done", 32'(bus.calib_done), 32'd0);
        chk("abort bsl", 32'(bus.bsl_active), 32'h0);
        chk("abort out", 32'(bus.data_out), 32'h0);
        step();
        reset = 1'b0;
        step();
        calib(12'h020, 12'h010, 12'h011, -1);
        chk("fresh bsl", 32'(bus.bsl_active), 32'h1120);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [NCH*NB_DATA-1:0] d;
            for (int c = 0; c < NCH; c++) begin
                int v;
                v = ($urandom % 4 == 0) ? int'($urandom % 4096)
                                        : int'($urandom % 400);
                d[c*NB_DATA +: NB_DATA] = NB_DATA'(v);
            end
            bus.data_in = d;
            bus.bsl_manual = NCH*NB_BSL'($urandom);
            if ($urandom % 32 == 0) bus.mode_auto = ~bus.mode_auto;
            bus.calib_start = ($urandom % 30 == 0);
            if ($urandom % 700 == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        bus.calib_start = 1'b0;
        step();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
